// File: rtl/jesd204_rx_frame_align_monitor_pkg.sv
// Shared definitions for the JESD204 RX frame-alignment monitor and its frame marker.
package jesd204_rx_frame_align_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_REALIGN = 2'd2
    } align_state_t;

    localparam int DPW_DEFAULT = 4;
    localparam int DPW_LOG2    = $clog2(DPW_DEFAULT);

    // Only 4- and 8-octet datapaths exist, so the log2 is one of two values.
    function automatic int dpw_log2(input int dpw);
        return (dpw == 8) ? 3 : 2;
    endfunction

endpackage

// File: rtl/jesd204_frame_mark.sv
// Per-octet frame/multiframe marker generator; shared by the RX and TX link layers.
module jesd204_frame_mark
    import jesd204_rx_frame_align_monitor_pkg::*;
#(
    parameter int DPW = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           in_valid_i,
    input  logic [7:0]     cfg_octets_per_frame_i,
    input  logic [9:0]     cfg_octets_per_multiframe_i,
    output logic [DPW-1:0] sof_o,
    output logic [DPW-1:0] eof_o,
    output logic [DPW-1:0] somf_o,
    output logic [DPW-1:0] eomf_o
);

    localparam int LOG2 = dpw_log2(DPW);

    logic [7:0]     frame_pos_q, frame_pos_d;
    logic [9:0]     mf_beat_q, mf_beat_d;
    logic [9:0]     mf_last;
    logic [10:0]    mf_octets;
    logic [10:0]    mf_beats;
    logic [7:0]     oct_pos [DPW];
    logic [DPW-1:0] sof_raw, eof_raw;

    assign mf_octets = {1'b0, cfg_octets_per_multiframe_i} + 11'd1;
    assign mf_beats  = (mf_octets >> LOG2) - 11'd1;
    assign mf_last   = mf_beats[9:0];

    // Octet positions are a chained wrap-increment so any F up to 256 works.
    genvar gi;
    assign oct_pos[0] = frame_pos_q;
    for (gi = 1; gi < DPW; gi++) begin : g_chain
        assign oct_pos[gi] = (oct_pos[gi-1] == cfg_octets_per_frame_i) ? 8'd0 : oct_pos[gi-1] + 8'd1;
    end

    for (gi = 0; gi < DPW; gi++) begin : g_mark
        assign sof_raw[gi] = (oct_pos[gi] == 8'd0);
        assign eof_raw[gi] = (oct_pos[gi] == cfg_octets_per_frame_i);
    end

    always_comb begin
        frame_pos_d = 8'd0;
        mf_beat_d   = 10'd0;
        if (in_valid_i) begin
            frame_pos_d = (oct_pos[DPW-1] == cfg_octets_per_frame_i) ? 8'd0 : oct_pos[DPW-1] + 8'd1;
            mf_beat_d   = (mf_beat_q == mf_last) ? 10'd0 : mf_beat_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_pos_q <= 8'd0;
            mf_beat_q   <= 10'd0;
        end else begin
            frame_pos_q <= frame_pos_d;
            mf_beat_q   <= mf_beat_d;
        end
    end

    // Marker content comes from registers; in_valid only qualifies it so idle beats carry no markers.
    assign sof_o  = in_valid_i ? sof_raw : '0;
    assign eof_o  = in_valid_i ? eof_raw : '0;
    assign somf_o = (in_valid_i && (mf_beat_q == 10'd0)) ? {{(DPW-1){1'b0}}, 1'b1} : '0;
    assign eomf_o = (in_valid_i && (mf_beat_q == mf_last)) ? {1'b1, {(DPW-1){1'b0}}} : '0;

endmodule

// File: rtl/jesd204_rx_frame_align_monitor.sv
// Checks /A/ and /F/ placement against generated frame markers and requests realignment on persistent errors.
module jesd204_rx_frame_align_monitor
    import jesd204_rx_frame_align_monitor_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int ERR_THRESHOLD   = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [7:0]                 cfg_octets_per_frame,
    input  logic [9:0]                 cfg_octets_per_multiframe,
    input  logic                       cfg_disable_scrambler,
    input  logic                       cfg_disable_char_replacement,
    input  logic                       in_valid,
    input  logic [DATA_PATH_WIDTH-1:0] char_is_a,
    input  logic [DATA_PATH_WIDTH-1:0] char_is_f,
    input  logic                       ctrl_err_clear,
    output logic [DATA_PATH_WIDTH-1:0] sof,
    output logic [DATA_PATH_WIDTH-1:0] eof,
    output logic [DATA_PATH_WIDTH-1:0] somf,
    output logic [DATA_PATH_WIDTH-1:0] eomf,
    output logic                       frame_align_err,
    output logic                       realign_request,
    output logic [7:0]                 status_err_count
);

    localparam int DPW = DATA_PATH_WIDTH;
    localparam logic [3:0] THR = 4'(ERR_THRESHOLD);

    align_state_t   state_q;
    logic [3:0]     consec_q, consec_d, consec_inc;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           frame_align_err_q;
    logic           check_en, checking, beat_bad, beat_good;
    logic [DPW-1:0] oct_legal, oct_illegal;

    jesd204_frame_mark #(.DPW(DPW)) u_frame_mark (
        .clk                         (clk),
        .resetn                      (resetn),
        .in_valid_i                  (in_valid),
        .cfg_octets_per_frame_i      (cfg_octets_per_frame),
        .cfg_octets_per_multiframe_i (cfg_octets_per_multiframe),
        .sof_o                       (sof),
        .eof_o                       (eof),
        .somf_o                      (somf),
        .eomf_o                      (eomf)
    );

    // Placement only means something when characters were actually inserted by an unscrambled TX.
    assign check_en = cfg_disable_scrambler && !cfg_disable_char_replacement;

    genvar gi;
    for (gi = 0; gi < DPW; gi++) begin : g_legal
        assign oct_legal[gi]   = (char_is_a[gi] && eomf[gi]) || (char_is_f[gi] && eof[gi] && !eomf[gi]);
        assign oct_illegal[gi] = (char_is_a[gi] && !eomf[gi]) || (char_is_f[gi] && !(eof[gi] && !eomf[gi]));
    end

    assign checking   = in_valid && check_en && (state_q != ST_REALIGN);
    assign beat_bad   = checking && (|oct_illegal);
    assign beat_good  = checking && (|oct_legal) && !(|oct_illegal);
    assign consec_inc = (consec_q == 4'hF) ? 4'hF : consec_q + 4'd1;

    always_comb begin
        consec_d = consec_q;
        if (!in_valid || !check_en) begin
            consec_d = 4'd0;
        end else if (beat_bad) begin
            consec_d = consec_inc;
        end else if (beat_good) begin
            consec_d = 4'd0;
        end

        err_cnt_d = err_cnt_q;
        if (ctrl_err_clear) begin
            err_cnt_d = 8'd0;
        end else if (beat_bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= ST_IDLE;
            consec_q          <= 4'd0;
            err_cnt_q         <= 8'd0;
            frame_align_err_q <= 1'b0;
        end else begin
            consec_q          <= consec_d;
            err_cnt_q         <= err_cnt_d;
            frame_align_err_q <= beat_bad;
            if (!in_valid) begin
                state_q <= ST_IDLE;
            end else if (state_q != ST_REALIGN) begin
                state_q <= (beat_bad && (consec_inc == THR)) ? ST_REALIGN : ST_LOCKED;
            end
        end
    end

    assign frame_align_err  = frame_align_err_q;
    assign realign_request  = (state_q == ST_REALIGN);
    assign status_err_count = err_cnt_q;

endmodule

// File: tb/tb_jesd204_rx_frame_align_monitor.sv
// Randomized and directed bench for the frame-alignment monitor with an octet-index reference model.
module tb_jesd204_rx_frame_align_monitor;

    localparam int DPW = 4;
    localparam int THR = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cfg_octets_per_frame = 8'd3;
    logic [9:0] cfg_octets_per_multiframe = 10'd31;
    logic       cfg_disable_scrambler = 1'b1;
    logic       cfg_disable_char_replacement = 1'b0;
    logic       in_valid = 1'b0;
    logic [DPW-1:0] char_is_a = '0;
    logic [DPW-1:0] char_is_f = '0;
    logic       ctrl_err_clear = 1'b0;
    logic [DPW-1:0] sof, eof, somf, eomf;
    logic       frame_align_err, realign_request;
    logic [7:0] status_err_count;

    always #5 clk = ~clk;

    jesd204_rx_frame_align_monitor #(.DATA_PATH_WIDTH(DPW), .ERR_THRESHOLD(THR)) dut (
        .clk                          (clk),
        .resetn                       (resetn),
        .cfg_octets_per_frame         (cfg_octets_per_frame),
        .cfg_octets_per_multiframe    (cfg_octets_per_multiframe),
        .cfg_disable_scrambler        (cfg_disable_scrambler),
        .cfg_disable_char_replacement (cfg_disable_char_replacement),
        .in_valid                     (in_valid),
        .char_is_a                    (char_is_a),
        .char_is_f                    (char_is_f),
        .ctrl_err_clear               (ctrl_err_clear),
        .sof                          (sof),
        .eof                          (eof),
        .somf                         (somf),
        .eomf                         (eomf),
        .frame_align_err              (frame_align_err),
        .realign_request              (realign_request),
        .status_err_count             (status_err_count)
    );

    int n_vec = 0;
    int n_fail = 0;

    // Reference model: position derived from the absolute octet index since the lane entered DATA.
    int m_beat = 0;
    int m_cnt = 0;
    int m_consec = 0;
    bit m_realign = 1'b0;
    bit m_pulse = 1'b0;
    logic [DPW-1:0] last_sof, last_eof, last_somf, last_eomf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_marks(input int beat, input bit v,
                                        output logic [DPW-1:0] s, output logic [DPW-1:0] e,
                                        output logic [DPW-1:0] sm, output logic [DPW-1:0] em);
        int flen, kf, n;
        flen = int'(cfg_octets_per_frame) + 1;
        kf   = int'(cfg_octets_per_multiframe) + 1;
        s = '0; e = '0; sm = '0; em = '0;
        if (v) begin
            for (int i = 0; i < DPW; i++) begin
                n = beat * DPW + i;
                s[i]  = (n % flen == 0);
                e[i]  = (n % flen == flen - 1);
                sm[i] = (i == 0) && (n % kf == 0);
                em[i] = (i == DPW - 1) && (n % kf == kf - 1);
            end
        end
    endfunction

    task automatic model_reset();
        m_beat = 0; m_cnt = 0; m_consec = 0; m_realign = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic set_cfg(input int flen, input int kf, input bit scr_dis, input bit cr_dis);
        cfg_octets_per_frame         = 8'(flen - 1);
        cfg_octets_per_multiframe    = 10'(kf - 1);
        cfg_disable_scrambler        = scr_dis;
        cfg_disable_char_replacement = cr_dis;
    endtask

    // One beat: drive, check markers and registered outputs at negedge, advance model at posedge.
    task automatic step(input bit v, input logic [DPW-1:0] a, input logic [DPW-1:0] f, input bit clr);
        logic [DPW-1:0] s, e, sm, em;
        bit ce, chk, ill, hit, bad, good;
        in_valid = v; char_is_a = a; char_is_f = f; ctrl_err_clear = clr;
        model_marks(m_beat, v, s, e, sm, em);
        @(negedge clk);
        last_sof = sof; last_eof = eof; last_somf = somf; last_eomf = eomf;
        check_val("sof", sof, s);
        check_val("eof", eof, e);
        check_val("somf", somf, sm);
        check_val("eomf", eomf, em);
        check_val("frame_align_err", frame_align_err, m_pulse);
        check_val("realign_request", realign_request, m_realign);
        check_val("status_err_count", status_err_count, m_cnt);
        ce  = cfg_disable_scrambler && !cfg_disable_char_replacement;
        chk = v && ce && !m_realign;
        ill = 1'b0; hit = 1'b0;
        for (int i = 0; i < DPW; i++) begin
            if (a[i]) begin
                if (em[i]) hit = 1'b1; else ill = 1'b1;
            end
            if (f[i]) begin
                if (e[i] && !em[i]) hit = 1'b1; else ill = 1'b1;
            end
        end
        bad  = chk && ill;
        good = chk && hit && !ill;
        @(posedge clk);
        m_pulse = bad;
        if (clr) m_cnt = 0;
        else if (bad && m_cnt < 255) m_cnt++;
        if (!v) begin
            m_consec = 0; m_realign = 1'b0; m_beat = 0;
        end else begin
            if (!ce) m_consec = 0;
            else if (bad) m_consec = (m_consec < 15) ? m_consec + 1 : 15;
            else if (good) m_consec = 0;
            if (bad && m_consec == THR) m_realign = 1'b1;
            m_beat++;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [DPW-1:0] eof_pat [3];
        logic [DPW-1:0] s, e, sm, em, a, f;
        int flen, k, kf, nb;
        eof_pat = '{4'b0100, 4'b0010, 4'b1001};

        // Reset state
        #1;
        check_val("rst_sof", sof, 0);
        check_val("rst_err", frame_align_err, 0);
        check_val("rst_realign", realign_request, 0);
        check_val("rst_cnt", status_err_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // F=3, K*F=96 marker sequence
        set_cfg(3, 96, 1, 0);
        step(0, '0, '0, 0);
        for (int b = 0; b < 25; b++) begin
            step(1, '0, '0, 0);
            if (b < 3) check_val("f3_eof", last_eof, eof_pat[b]);
            if (b == 23) begin
                check_val("f3_eomf23", last_eomf, 4'b1000);
                check_val("f3_eof23", last_eof, 4'b1001);
            end
            if (b == 0 || b == 24) check_val("f3_somf", last_somf, 4'b0001);
        end
        step(0, '0, '0, 0);

        // Legal placement, F=4, K*F=32
        set_cfg(4, 32, 1, 0);
        for (int b = 0; b < 8; b++)
            step(1, (b == 7) ? 4'b1000 : 4'b0000, (b == 5) ? 4'b1000 : 4'b0000, 0);
        check_val("legal_cnt", status_err_count, 0);
        step(0, '0, '0, 0);

        // Four consecutive misplaced /F/ -> realign
        for (int b = 0; b < 4; b++) begin
            step(1, '0, 4'b0010, 0);
            check_val("realign_level", realign_request, (b == 3) ? 1 : 0);
        end
        check_val("realign_cnt", status_err_count, 4);
        step(0, '0, '0, 0);
        check_val("realign_clear", realign_request, 0);
        step(0, '0, '0, 1);
        check_val("clear_cnt", status_err_count, 0);

        // Good beat breaks the run
        for (int b = 0; b < 7; b++)
            step(1, '0, (b == 3) ? 4'b1000 : 4'b0010, 0);
        check_val("run_realign", realign_request, 0);
        check_val("run_cnt", status_err_count, 6);
        step(0, '0, '0, 1);

        // Check disabled
        set_cfg(4, 32, 0, 0);
        step(0, '0, '0, 0);
        for (int b = 0; b < 10; b++) step(1, 4'b0001, 4'b0010, 0);
        check_val("dis_cnt", status_err_count, 0);
        step(0, '0, '0, 0);

        // Saturation with interleaved good beats
        set_cfg(4, 32, 1, 0);
        step(0, '0, '0, 0);
        for (int b = 0; b < 520; b++) begin
            if (b % 8 == 7) step(1, 4'b1000, '0, 0);
            else if (b % 3 == 2) step(1, '0, 4'b1000, 0);
            else step(1, '0, 4'b0010, 0);
        end
        check_val("sat_cnt", status_err_count, 255);
        step(0, '0, '0, 1);
        check_val("sat_clear", status_err_count, 0);

        // Reset while in REALIGN
        for (int b = 0; b < 6; b++) step(1, '0, 4'b0010, 0);
        check_val("pre_rst_realign", realign_request, 1);
        #2;
        resetn = 1'b0; in_valid = 1'b0; char_is_a = '0; char_is_f = '0;
        #1;
        check_val("mid_rst_sof", sof, 0);
        check_val("mid_rst_somf", somf, 0);
        check_val("mid_rst_err", frame_align_err, 0);
        check_val("mid_rst_realign", realign_request, 0);
        check_val("mid_rst_cnt", status_err_count, 0);
        model_reset();
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        step(1, '0, '0, 0);
        check_val("post_rst_somf", last_somf, 4'b0001);
        step(0, '0, '0, 0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            flen = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(1, 20));
            k = 4;
            for (int t = 0; t < 200; t++) begin
                kf = int'($urandom_range(1, 32));
                if ((kf * flen) % DPW == 0 && kf * flen <= 1024) begin
                    k = kf;
                    break;
                end
            end
            kf = k * flen;
            set_cfg(flen, kf, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
            step(0, '0, '0, 0);
            nb = int'($urandom_range(10, 150));
            for (int b = 0; b < nb; b++) begin
                model_marks(m_beat, 1'b1, s, e, sm, em);
                a = em & DPW'($urandom_range(0, 15));
                f = (e & ~em) & DPW'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) a = a | DPW'(1 << $urandom_range(0, DPW - 1));
                if ($urandom_range(0, 19) == 0) f = f | DPW'(1 << $urandom_range(0, DPW - 1));
                step(1, a, f, $urandom_range(0, 49) == 0);
            end
            for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                step(0, DPW'($urandom_range(0, 15)), DPW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
